// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings and FSM state types for axi_sram_slave.
// The R_WAIT state exists only when AXI_SRAM_LATENCY_EN is defined.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

`ifdef AXI_SRAM_LATENCY_EN
  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;
`else
  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA
  } rd_state_e;
`endif

  // WRAP is deliberately handled like INCR; only FIXED holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4 channel bundle between a master and axi_sram_slave.
interface axi_sram_slave_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/axi_sram_slave_mem.sv
// axi_sram_slave_mem: DEPTH_WORDS x 32 array, byte-enable write port and
// asynchronous read port. A read and a write to the same word on one edge
// see the old contents on the read side. Contents are never reset.
module axi_sram_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // byte-lane write
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave fronting a word-addressed SRAM, independent
// read/write FSMs, one outstanding burst per direction.
// Define AXI_SRAM_LATENCY_EN to insert LAT_CYCLES read wait states.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
`ifdef AXI_SRAM_LATENCY_EN
  ,
  parameter int unsigned LAT_CYCLES  = 4
`endif
) (
  input logic             clock,
  input logic             reset_n,
  axi_sram_slave_if.slave io_slave
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  // unsigned offset compare also rejects addresses below BASE_ADDR
  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  wr_state_e   wst_q, wst_d;
  logic [31:0] waddr_q, waddr_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic [3:0]  bid_q, bid_d;
  logic        wr_err_q, wr_err_d;
  logic        mem_we;

  rd_state_e   rd_st_q, rd_st_d;
  logic [31:0] raddr_q, raddr_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
`ifdef AXI_SRAM_LATENCY_EN
  logic [7:0]  lat_q, lat_d;
`endif

  logic        ld_beat;
  logic [2:0]  ld_size;
  logic [1:0]  ld_burst;
  logic [7:0]  ld_rem;
  logic [31:0] rd_src;
  logic        rd_ok;
  logic [31:0] mem_rdata;

  // burst length is not tracked on the write side; wlast ends the burst
  logic unused_awlen;
  assign unused_awlen = ^io_slave.awlen;

  assign rd_src = (rd_st_q == R_IDLE) ? io_slave.araddr : raddr_q;
  assign rd_ok  = in_range(rd_src);

  axi_sram_slave_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .be    (io_slave.wstrb),
    .waddr (word_idx(waddr_q)),
    .wdata (io_slave.wdata),
    .raddr (word_idx(rd_src)),
    .rdata (mem_rdata)
  );

  // write FSM next state; out-of-range beats are dropped and make the response SLVERR
  always_comb begin
    wst_d    = wst_q;
    waddr_d  = waddr_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    bid_d    = bid_q;
    wr_err_d = wr_err_q;
    mem_we   = 1'b0;
    unique case (wst_q)
      W_IDLE: if (io_slave.awvalid) begin
        waddr_d  = io_slave.awaddr;
        wsize_d  = io_slave.awsize;
        wburst_d = io_slave.awburst;
        bid_d    = io_slave.awid;
        wr_err_d = 1'b0;
        wst_d    = W_DATA;
      end
      W_DATA: if (io_slave.wvalid) begin
        mem_we   = in_range(waddr_q);
        wr_err_d = wr_err_q | ~in_range(waddr_q);
        waddr_d  = next_addr(waddr_q, wsize_q, wburst_q);
        if (io_slave.wlast) wst_d = W_RESP;
      end
      W_RESP: if (io_slave.bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // write FSM registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wst_q    <= W_IDLE;
      waddr_q  <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      bid_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      waddr_q  <= waddr_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      bid_q    <= bid_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign io_slave.awready = (wst_q == W_IDLE);
  assign io_slave.wready  = (wst_q == W_DATA);
  assign io_slave.bvalid  = (wst_q == W_RESP);
  assign io_slave.bresp   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
  assign io_slave.bid     = bid_q;

  // read FSM next state; ld_beat registers the next beat, rcnt counts beats left after it
  always_comb begin
    rd_st_d  = rd_st_q;
    raddr_d  = raddr_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rid_d    = rid_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ld_beat  = 1'b0;
    ld_size  = rsize_q;
    ld_burst = rburst_q;
    ld_rem   = rcnt_q;
`ifdef AXI_SRAM_LATENCY_EN
    lat_d    = lat_q;
`endif
    unique case (rd_st_q)
      R_IDLE: if (io_slave.arvalid) begin
        raddr_d  = io_slave.araddr;
        rsize_d  = io_slave.arsize;
        rburst_d = io_slave.arburst;
        rid_d    = io_slave.arid;
        rcnt_d   = io_slave.arlen;
`ifdef AXI_SRAM_LATENCY_EN
        lat_d    = 8'(LAT_CYCLES - 1);
        rd_st_d  = R_WAIT;
`else
        ld_beat  = 1'b1;
        ld_size  = io_slave.arsize;
        ld_burst = io_slave.arburst;
        ld_rem   = io_slave.arlen;
        rd_st_d  = R_DATA;
`endif
      end
`ifdef AXI_SRAM_LATENCY_EN
      R_WAIT: begin
        if (lat_q == '0) begin
          ld_beat = 1'b1;
          rd_st_d = R_DATA;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
`endif
      R_DATA: if (io_slave.rready) begin
        if (rcnt_q != '0) begin
          ld_beat = 1'b1;
          ld_rem  = rcnt_q - 8'd1;
        end else begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          rd_st_d  = R_IDLE;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
    if (ld_beat) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? mem_rdata : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      rlast_d  = (ld_rem == '0);
      rcnt_d   = ld_rem;
      raddr_d  = next_addr(rd_src, ld_size, ld_burst);
    end
  end

  // read FSM registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_st_q  <= R_IDLE;
      raddr_q  <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rid_q    <= '0;
      rcnt_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
`ifdef AXI_SRAM_LATENCY_EN
      lat_q    <= '0;
`endif
    end else begin
      rd_st_q  <= rd_st_d;
      raddr_q  <= raddr_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rid_q    <= rid_d;
      rcnt_q   <= rcnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
`ifdef AXI_SRAM_LATENCY_EN
      lat_q    <= lat_d;
`endif
    end
  end

  assign io_slave.arready = (rd_st_q == R_IDLE);
  assign io_slave.rvalid  = rvalid_q;
  assign io_slave.rdata   = rdata_q;
  assign io_slave.rresp   = rresp_q;
  assign io_slave.rlast   = rlast_q;
  assign io_slave.rid     = rid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed + randomized bursts against a byte-level memory model.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          TMO   = 200;
`ifdef AXI_SRAM_LATENCY_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  axi_sram_slave_if bus ();

  axi_sram_slave dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .io_slave (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wq [$];
  logic [3:0]  sq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    if (burst == BURST_FIXED) return a;
    return a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // sends wq/sq as one burst, then collects B with bstall cycles of bready=0
  task automatic axi_write(input logic [31:0] a, input logic [3:0] id,
                           input logic [1:0] burst, input int bstall);
    int n;
    bit err;
    logic [31:0] ba;
    err = 0;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = id;
    bus.awlen = 8'(wq.size() - 1); bus.awsize = 3'd2; bus.awburst = burst;
    n = 0;
    while (bus.awready !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    check("aw_accept", 32'(n < TMO), 1);
    @(negedge clock);
    bus.awvalid = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      bus.wvalid = 1'b1; bus.wdata = wq[i]; bus.wstrb = sq[i];
      bus.wlast = (i == wq.size() - 1);
      n = 0;
      while (bus.wready !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
      check("w_accept", 32'(n < TMO), 1);
      ba = beat_addr(a, 3'd2, burst, i);
      if (in_rng(ba)) begin
        for (int b = 0; b < 4; b++)
          if (sq[i][b]) ref_mem[widx(ba)][8*b +: 8] = wq[i][8*b +: 8];
      end else begin
        err = 1;
      end
      @(negedge clock);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_next_cycle", bus.bvalid, 1);
    for (int c = 0; c < bstall; c++) begin
      @(negedge clock);
      check("bstall_bvalid", bus.bvalid, 1);
      check("bstall_bid", bus.bid, id);
      check("bstall_awready", bus.awready, 0);
    end
    bus.bready = 1'b1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    check("bresp", bus.bresp, err ? RESP_SLVERR : RESP_OKAY);
    check("bid", bus.bid, id);
    @(negedge clock);
    bus.bready = 1'b0;
    check("b_done_bvalid", bus.bvalid, 0);
    check("b_done_awready", bus.awready, 1);
  endtask

  // mode 0: rready always 1; 1: toggles 1/0; 2: random
  task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    int n, beats;
    bit stalled, tog, rdy;
    logic [31:0] pdata, ba, edata;
    logic plast;
    logic [1:0] eresp;
    pdata = '0; plast = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id;
    bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    n = 0;
    while (bus.arready !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    check("ar_accept", 32'(n < TMO), 1);
    @(negedge clock);
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    check("rd_first_latency", n, EXP_LAT);
    beats = 0; stalled = 0; tog = 1; n = 0;
    while (beats <= int'(len) && n < TMO * 4) begin
      check("rd_rvalid_held", bus.rvalid, 1);
      if (stalled) begin
        check("rd_stall_data", bus.rdata, pdata);
        check("rd_stall_last", bus.rlast, plast);
      end
      case (mode)
        0: rdy = 1;
        1: begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.rready = rdy;
      if (rdy) begin
        ba    = beat_addr(a, size, burst, beats);
        edata = in_rng(ba) ? ref_mem[widx(ba)] : 32'h0;
        eresp = in_rng(ba) ? RESP_OKAY : RESP_SLVERR;
        check("rd_data", bus.rdata, edata);
        check("rd_resp", bus.rresp, eresp);
        check("rd_last", bus.rlast, 32'(beats == int'(len)));
        check("rd_id", bus.rid, id);
        beats++;
        stalled = 0;
      end else begin
        stalled = 1; pdata = bus.rdata; plast = bus.rlast;
      end
      @(negedge clock);
      n++;
    end
    bus.rready = 1'b0;
    check("rd_beat_count", beats, int'(len) + 1);
    check("rd_done_rvalid", bus.rvalid, 0);
  endtask

  initial begin
    int w, len;
    logic [1:0] bu;
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_awready", bus.awready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_bid", bus.bid, 0);
    check("rst_rid", bus.rid, 0);

    // prefill words 0..255 with one 256-beat burst
    wq.delete(); sq.delete();
    for (int i = 0; i < 256; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
    axi_write(BASE, 4'h1, BURST_INCR, 0);
    axi_read(BASE + 32'h3F0, 4'h2, 8'd15, 3'd2, BURST_INCR, 0);

    // single-beat write/read
    wq = '{32'hDEAD_BEEF}; sq = '{4'hF};
    axi_write(32'h8000_0010, 4'h3, BURST_INCR, 0);
    axi_read(32'h8000_0010, 4'h4, 8'd0, 3'd2, BURST_INCR, 0);
    check("single_word_model", ref_mem[4], 32'hDEAD_BEEF);

    // partial strobe merge
    wq = '{32'h1234_5678}; sq = '{4'b0011};
    axi_write(32'h8000_0010, 4'h5, BURST_INCR, 0);
    axi_read(32'h8000_0010, 4'h6, 8'd0, 3'd2, BURST_INCR, 0);

    // INCR len3 with rready toggling
    axi_read(BASE, 4'h7, 8'd3, 3'd2, BURST_INCR, 1);

    // out-of-range read and write, then word 0 must be untouched
    axi_read(32'h0000_0000, 4'h8, 8'd0, 3'd2, BURST_INCR, 0);
    wq = '{32'hBAD0_BAD0}; sq = '{4'hF};
    axi_write(32'h0000_0000, 4'h9, BURST_INCR, 0);
    axi_read(BASE, 4'hA, 8'd0, 3'd2, BURST_INCR, 0);

    // B channel backpressure for 5 cycles
    wq = '{32'hCAFE_F00D, 32'h0BAD_CAFE}; sq = '{4'hF, 4'hF};
    axi_write(BASE + 32'h40, 4'hB, BURST_INCR, 5);
    axi_read(BASE + 32'h40, 4'hC, 8'd1, 3'd2, BURST_INCR, 1);

    // FIXED bursts hit one word
    wq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    sq = '{4'hF, 4'b0001, 4'b1000, 4'b0100};
    axi_write(BASE + 32'h80, 4'hD, BURST_FIXED, 0);
    axi_read(BASE + 32'h80, 4'hE, 8'd2, 3'd2, BURST_FIXED, 2);

    // top boundary: second beat falls past the array
    wq = '{32'hA5A5_0001, 32'hA5A5_0002}; sq = '{4'hF, 4'hF};
    axi_write(BASE + 32'(4 * (DEPTH - 1)), 4'h2, BURST_INCR, 0);
    axi_read(BASE + 32'(4 * (DEPTH - 1)), 4'h3, 8'd1, 3'd2, BURST_INCR, 0);

    // 32-bit address wrap
    axi_read(32'hFFFF_FFFC, 4'h4, 8'd1, 3'd2, BURST_INCR, 0);

    // WRAP handled as INCR
    wq = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002}; sq = '{4'hF, 4'hF, 4'hF};
    axi_write(BASE + 32'hC0, 4'h5, BURST_WRAP, 0);
    axi_read(BASE + 32'hC0, 4'h6, 8'd2, 3'd2, BURST_WRAP, 0);

    // narrow reads return the whole aligned word
    axi_read(BASE + 32'h10, 4'h7, 8'd3, 3'd0, BURST_INCR, 0);
    axi_read(BASE + 32'h40, 4'h8, 8'd3, 3'd1, BURST_INCR, 1);

    // wvalid with no AW in flight is not accepted
    bus.wvalid = 1'b1; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("w_before_aw_wready", bus.wready, 0);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    axi_read(BASE, 4'h9, 8'd7, 3'd2, BURST_INCR, 0);

    // randomized write-then-read bursts
    for (int t = 0; t < 20; t++) begin
      w   = int'($urandom_range(0, 240));
      len = int'($urandom_range(0, 7));
      bu  = 2'($urandom_range(0, 2));
      wq.delete(); sq.delete();
      for (int i = 0; i <= len; i++) begin
        wq.push_back($urandom);
        sq.push_back(4'($urandom_range(0, 15)));
      end
      axi_write(BASE + 32'(4 * w), 4'($urandom_range(0, 15)), bu, int'($urandom_range(0, 3)));
      axi_read(BASE + 32'(4 * w), 4'($urandom_range(0, 15)), 8'(len),
               3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // reset in the middle of a stalled read burst
    bus.arvalid = 1'b1; bus.araddr = BASE; bus.arid = 4'h5; bus.arlen = 8'd7;
    bus.arsize = 3'd2; bus.arburst = BURST_INCR; bus.rready = 1'b0;
    @(negedge clock);
    bus.arvalid = 1'b0;
    repeat (EXP_LAT + 2) @(negedge clock);
    check("pre_reset_rvalid", bus.rvalid, 1);
    check("pre_reset_arready", bus.arready, 0);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_rvalid", bus.rvalid, 0);
    check("async_reset_rdata", bus.rdata, 0);
    check("async_reset_rid", bus.rid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_arready", bus.arready, 1);
    check("post_reset_awready", bus.awready, 1);
    check("post_reset_rvalid", bus.rvalid, 0);
    axi_read(BASE + 32'h20, 4'h6, 8'd2, 3'd2, BURST_INCR, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
